sampletest_ms: RTL and testbench
================================

# sampletest_ms

Multi-sample successor to the single-sample triangle sample test in the raster pipeline. Accepts one triangle plus one pixel location with a table of `SAMPLES` subsample offsets, then serially evaluates the three edge equations at each subsample. It emits one beat per subsample on a valid/ready output, each carrying the sample position, triangle colour and a hit flag. The final beat also carries an accumulated coverage mask. It sits between the sample iterator and the z-test/shade stage.

## Interface
Parameters:
- `SIGFIG` = 24 — bits in colour and position.
- `RADIX` = 10 — fraction bits.
- `AXIS` = 3 — axes per vertex (x,y,z).
- `COLORS` = 3 — colour channels.
- `SAMPLES` = 4 — subsamples per pixel, 1..16.
- `SHORTSF` = 16 — signed width kept after the coordinate shift. Products are `2*SHORTSF` wide.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `in_valid` in 1 — input beat valid.
- `in_ready` out 1 — block can accept an input beat.
- `tri_in[2:0][AXIS-1:0]` in `SIGFIG` signed — vertices.
- `color_in[COLORS-1:0]` in `SIGFIG` unsigned — triangle colour.
- `pix_in[1:0]` in `SIGFIG` signed — pixel base (x,y).
- `offs_in[SAMPLES-1:0][1:0]` in `SIGFIG` signed — subsample offsets.
- `cull_mode` in 2 — 0 back-cull, 1 front-cull, 2 none, 3 same as 0.
- `out_valid` out 1 — output beat valid.
- `out_ready` in 1 — downstream accepts the output beat.
- `hit_out[AXIS-1:0]` out `SIGFIG` signed — sample x, y, and z of vertex 0.
- `color_out[COLORS-1:0]` out `SIGFIG` unsigned — triangle colour.
- `hit_valid_out` out 1 — sample is covered.
- `samp_idx_out` out `$clog2(SAMPLES)` (min 1) — subsample index.
- `last_out` out 1 — final subsample of the pixel.
- `covmask_out` out `SAMPLES` — coverage mask. Bit i = hit of sample i. Valid only when `last_out`=1, zero otherwise.

## Operation
FSM has two states, IDLE and ITER.

IDLE:
- `in_ready`=1.
- On `in_valid`: latch `tri_in`, `color_in`, `pix_in`, `offs_in` and `cull_mode`; set idx=0 and covmask accumulator=0; go to ITER.

ITER:
- `in_ready`=0.
- Load condition is `!out_valid || out_ready`. When it holds, the output register loads the result for sample idx and idx increments.
- On loading idx=`SAMPLES-1`: `last_out`=1, `covmask_out` = accumulator with bit idx applied, go to IDLE.

Per-sample arithmetic for sample s:
- Position: s = pix + offs[idx], full `SIGFIG` add with wrap.
- Shift: `v'[k]` = vertex k minus s. Keep the low `SHORTSF` bits; out-of-range values wrap and the result is unspecified but deterministic.
- Edge values in `2*SHORTSF` signed arithmetic:
  - d0 = x0·y1 − x1·y0
  - d1 = x1·y2 − x2·y1
  - d2 = x2·y0 − x0·y2
- Back-facing-accept test (neg): d0≤0 and d1<0 and d2≤0.
- Front test (pos): d0≥0 and d1>0 and d2≥0.
- Hit rule by mode:
  - Mode 0/3: hit = neg.
  - Mode 1: hit = pos.
  - Mode 2: hit = neg or pos.
- Edge 1 is always strict, so d1=0 never hits.

Output fields:
- `hit_out` = {tri[0].z, s.y, s.x}.
- `color_out` = latched colour.

Assertion: `out_valid && hit_valid_out` implies d1≠0 for that sample.

Reset values: state IDLE, idx 0, `out_valid` 0, `hit_valid_out` 0, `last_out` 0, `covmask_out` 0, `samp_idx_out` 0, `hit_out` 0, `color_out` 0, accumulator 0.

Boundary conditions:
- A beat stalled by `out_ready`=0 holds every output field stable.
- `in_valid` in ITER is ignored.
- `SAMPLES`=1: a single beat with `last_out`=1.
- `rst` asserted mid-pixel drops the pixel immediately. There is no partial output after reset.

## Timing
- Input accepted at edge T → first output beat valid after edge T+1.
- Beats follow back-to-back at one per cycle while `out_ready`=1.
- The last beat loads at edge T+`SAMPLES`.
- The next input can be accepted at edge T+`SAMPLES`+1. Sustained throughput is one pixel per `SAMPLES`+1 cycles.
- The arithmetic path is combinational into the output register.

## Configuration
- `SAMPLETEST_MS_CULL_EN` defined: `cull_mode` is honoured as described above.
- `SAMPLETEST_MS_CULL_EN` not defined: the `cull_mode` port exists but is ignored, and the hit rule is always neg (back-cull).

## Test plan
All coordinates are in RADIX 10 (1.0 = 1024). Test triangle v0=(0,0), v1=(0,4096), v2=(4096,0), z0=77. Base pixel (1024,1024). Offsets (0,0), (512,512), (2048,2048), (−2048,0).

1. Mode 0, `out_ready`=1 → four beats, `hit_valid` = 1,1,0,0, `hit_out` x/y = (1024,1024), (1536,1536), (3072,3072), (−1024,1024), z=77. `last_out` on idx 3 with `covmask_out`=4'b0011. `in_ready` returns to 1 one cycle after the last load.
2. Same test with v1 and v2 swapped:
   - Mode 0 → covmask 4'b0000.
   - Mode 1 → 4'b0011 with `SAMPLETEST_MS_CULL_EN` defined, 4'b0000 without.
   - Mode 2 → 4'b0011 with the macro defined.
3. Ties, `SAMPLES`=1, offset (0,0):
   - Pixel (0,1024): d0=0 → hit=1.
   - Pixel (2048,2048): d1=0 → hit=0, and the assertion does not fire.
4. Backpressure: hold `out_ready`=0 for 3 cycles on beat idx 1 → outputs stable and `in_valid` ignored. The remaining beats complete in order with covmask 4'b0011.
5. Pulse `rst` while idx=2 → next cycle `out_valid`=0, `in_ready`=1, `covmask_out`=0. A new pixel then starts from idx 0.

Source files
------------

// File: rtl/sampletest_ms.sv
// Multi-sample triangle coverage test: one pixel in, one beat per subsample out.
// Optional feature macro: SAMPLETEST_MS_CULL_EN (honour cull_mode; otherwise always back-cull).
module sampletest_ms #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 4,
  parameter int SHORTSF = 16,
  localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [2:0][AXIS-1:0][SIGFIG-1:0]  tri_in,
  input  logic [COLORS-1:0][SIGFIG-1:0]            color_in,
  input  logic signed [1:0][SIGFIG-1:0]            pix_in,
  input  logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] offs_in,
  input  logic [1:0]                               cull_mode,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [AXIS-1:0][SIGFIG-1:0]       hit_out,
  output logic [COLORS-1:0][SIGFIG-1:0]            color_out,
  output logic                                     hit_valid_out,
  output logic [IW-1:0]                            samp_idx_out,
  output logic                                     last_out,
  output logic [SAMPLES-1:0]                       covmask_out
);
  localparam int PW = 2 * SHORTSF;
  localparam int unused_radix = RADIX;

  typedef enum logic {IDLE, ITER} state_t;
  state_t state, state_nx;

  logic signed [2:0][AXIS-1:0][SIGFIG-1:0]    tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]              color_q;
  logic signed [1:0][SIGFIG-1:0]              pix_q;
  logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] offs_q;
  logic [1:0]                                 mode_q;
  logic [IW-1:0]                              idx;
  logic [SAMPLES-1:0]                         acc, acc_nx;

  logic [SIGFIG-1:0]         sx, sy;
  logic signed [SHORTSF-1:0] vx [3];
  logic signed [SHORTSF-1:0] vy [3];
  logic signed [PW-1:0]      ex [3];
  logic signed [PW-1:0]      ey [3];
  logic signed [PW-1:0]      d0, d1, d2;
  logic neg, pos, hit, load, last;

  // Only the low SHORTSF bits of the shifted coordinates matter; upper bits wrap away.
  always_comb begin
    sx = pix_q[0] + offs_q[idx][0];
    sy = pix_q[1] + offs_q[idx][1];
    for (int k = 0; k < 3; k++) begin
      vx[k] = tri_q[k][0][SHORTSF-1:0] - sx[SHORTSF-1:0];
      vy[k] = tri_q[k][1][SHORTSF-1:0] - sy[SHORTSF-1:0];
      ex[k] = PW'(vx[k]);
      ey[k] = PW'(vy[k]);
    end
    d0 = ex[0] * ey[1] - ex[1] * ey[0];
    d1 = ex[1] * ey[2] - ex[2] * ey[1];
    d2 = ex[2] * ey[0] - ex[0] * ey[2];
    // Edge 1 is strict in both orientations so shared edges never double-hit.
    neg = (d0[PW-1] || ~|d0) && d1[PW-1] && (d2[PW-1] || ~|d2);
    pos = !d0[PW-1] && (!d1[PW-1] && |d1) && !d2[PW-1];
`ifdef SAMPLETEST_MS_CULL_EN
    case (mode_q)
      2'd1:    hit = pos;
      2'd2:    hit = neg || pos;
      default: hit = neg;
    endcase
`else
    hit = neg;
`endif
    load   = !out_valid || out_ready;
    last   = (idx == IW'(SAMPLES - 1));
    acc_nx = acc | (SAMPLES'(hit) << idx);
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ITER;
      end
      ITER: if (load && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      acc           <= '0;
      tri_q         <= '0;
      color_q       <= '0;
      pix_q         <= '0;
      offs_q        <= '0;
      mode_q        <= '0;
      out_valid     <= 1'b0;
      hit_out       <= '0;
      color_out     <= '0;
      hit_valid_out <= 1'b0;
      samp_idx_out  <= '0;
      last_out      <= 1'b0;
      covmask_out   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (out_ready) out_valid <= 1'b0;
        if (in_valid) begin
          tri_q   <= tri_in;
          color_q <= color_in;
          pix_q   <= pix_in;
          offs_q  <= offs_in;
          mode_q  <= cull_mode;
          idx     <= '0;
          acc     <= '0;
        end
      end else if (load) begin
        out_valid     <= 1'b1;
        hit_out       <= '0;
        hit_out[0]    <= sx;
        hit_out[1]    <= sy;
        hit_out[2]    <= tri_q[0][2];
        color_out     <= color_q;
        hit_valid_out <= hit;
        samp_idx_out  <= idx;
        last_out      <= last;
        covmask_out   <= last ? acc_nx : '0;
        acc           <= acc_nx;
        idx           <= idx + 1'b1;
      end
    end
  end

  logic unused_bits;
`ifdef SAMPLETEST_MS_CULL_EN
  assign unused_bits = ^{tri_q[1][2], tri_q[2][2], tri_q[0][1:0], tri_q[1][1:0], tri_q[2][1:0]};
`else
  assign unused_bits = ^{tri_q[1][2], tri_q[2][2], tri_q[0][1:0], tri_q[1][1:0], tri_q[2][1:0],
                         mode_q};
`endif

  a_hit_strict: assert property (@(posedge clk) disable iff (rst)
    (state == ITER && load && hit) |-> (d1 != PW'(0)));
endmodule

// File: tb/tb_sampletest_ms.sv
// Bench for sampletest_ms: table vectors, hand-written corner sequences, random pixels vs. model.
module tb_sampletest_ms;
  localparam int SW = 24;
  localparam int S  = 4;
`ifdef SAMPLETEST_MS_CULL_EN
  localparam logic [3:0] CULL_M = 4'b0011;
`else
  localparam logic [3:0] CULL_M = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready, hit_valid_out, last_out;
  logic signed [2:0][2:0][SW-1:0]   tri_in;
  logic [2:0][SW-1:0]               color_in;
  logic signed [1:0][SW-1:0]        pix_in;
  logic signed [S-1:0][1:0][SW-1:0] offs_in;
  logic [1:0]                       cull_mode;
  logic signed [2:0][SW-1:0]        hit_out;
  logic [2:0][SW-1:0]               color_out;
  logic [1:0]                       samp_idx_out;
  logic [S-1:0]                     covmask_out;

  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hit_valid, b_last;
  logic signed [1:0][SW-1:0]        b_pix;
  logic signed [0:0][1:0][SW-1:0]   b_offs;
  logic signed [2:0][SW-1:0]        b_hit_out;
  logic [2:0][SW-1:0]               b_color_out;
  logic [0:0]                       b_idx, b_mask;

  sampletest_ms #(.SAMPLES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tri_in(tri_in),
    .color_in(color_in), .pix_in(pix_in), .offs_in(offs_in), .cull_mode(cull_mode),
    .out_valid(out_valid), .out_ready(out_ready), .hit_out(hit_out), .color_out(color_out),
    .hit_valid_out(hit_valid_out), .samp_idx_out(samp_idx_out), .last_out(last_out),
    .covmask_out(covmask_out));

  sampletest_ms #(.SAMPLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .tri_in(tri_in),
    .color_in(color_in), .pix_in(b_pix), .offs_in(b_offs), .cull_mode(cull_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .hit_out(b_hit_out),
    .color_out(b_color_out), .hit_valid_out(b_hit_valid), .samp_idx_out(b_idx),
    .last_out(b_last), .covmask_out(b_mask));

  typedef struct packed {
    logic [2:0][31:0]   vx, vy;
    logic [31:0]        z0, px, py;
    logic [S-1:0][31:0] ox, oy;
    logic [1:0]         mode;
    logic [2:0][SW-1:0] col;
  } pix_t;

  typedef struct packed {
    logic       swap;
    logic [1:0] mode;
    logic [3:0] mask;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic longint sg(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic int wrapn(input longint v, input int n);
    longint m, r;
    m = longint'(1) << n;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return int'(r);
  endfunction

  // Sample position, shifted vertices, edge cross products, then the hit rule.
  function automatic bit model_hit(input pix_t p, input int s);
    int sx, sy, d0, d1, d2;
    int x [3];
    int y [3];
    bit neg, pos;
    sx = wrapn(sg(p.px) + sg(p.ox[s]), SW);
    sy = wrapn(sg(p.py) + sg(p.oy[s]), SW);
    for (int k = 0; k < 3; k++) begin
      x[k] = wrapn(sg(p.vx[k]) - sx, 16);
      y[k] = wrapn(sg(p.vy[k]) - sy, 16);
    end
    d0 = wrapn(longint'(x[0]) * y[1] - longint'(x[1]) * y[0], 32);
    d1 = wrapn(longint'(x[1]) * y[2] - longint'(x[2]) * y[1], 32);
    d2 = wrapn(longint'(x[2]) * y[0] - longint'(x[0]) * y[2], 32);
    neg = (d0 <= 0) && (d1 < 0) && (d2 <= 0);
    pos = (d0 >= 0) && (d1 > 0) && (d2 >= 0);
`ifdef SAMPLETEST_MS_CULL_EN
    case (p.mode)
      2'd1:    return pos;
      2'd2:    return neg || pos;
      default: return neg;
    endcase
`else
    return neg;
`endif
  endfunction

  function automatic pix_t base_pix(input logic swap, input logic [1:0] mode);
    pix_t p;
    p.vx = '0; p.vy = '0;
    p.vy[1] = 4096; p.vx[2] = 4096;
    if (swap) begin p.vy[1] = 0; p.vx[2] = 0; p.vx[1] = 4096; p.vy[2] = 4096; end
    p.z0 = 77; p.px = 1024; p.py = 1024;
    p.ox[0] = 0;     p.oy[0] = 0;
    p.ox[1] = 512;   p.oy[1] = 512;
    p.ox[2] = 2048;  p.oy[2] = 2048;
    p.ox[3] = -2048; p.oy[3] = 0;
    p.mode = mode;
    p.col[0] = 24'h123456; p.col[1] = 24'hABCDEF; p.col[2] = 24'h00FF00;
    return p;
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    for (int k = 0; k < 3; k++) begin
      p.vx[k] = $urandom_range(16383) - 8192;
      p.vy[k] = $urandom_range(16383) - 8192;
      p.col[k] = SW'($urandom());
    end
    for (int s = 0; s < S; s++) begin
      p.ox[s] = $urandom_range(4095) - 2048;
      p.oy[s] = $urandom_range(4095) - 2048;
    end
    p.z0 = $urandom_range(100000) - 50000;
    p.px = $urandom_range(8191) - 4096;
    p.py = $urandom_range(8191) - 4096;
    p.mode = 2'($urandom_range(3));
    return p;
  endfunction

  task automatic drive(input pix_t p);
    for (int k = 0; k < 3; k++) begin
      tri_in[k][0] = p.vx[k][SW-1:0];
      tri_in[k][1] = p.vy[k][SW-1:0];
      tri_in[k][2] = (k == 0) ? p.z0[SW-1:0] : SW'($urandom());
    end
    color_in = p.col;
    pix_in[0] = p.px[SW-1:0];
    pix_in[1] = p.py[SW-1:0];
    for (int s = 0; s < S; s++) begin
      offs_in[s][0] = p.ox[s][SW-1:0];
      offs_in[s][1] = p.oy[s][SW-1:0];
    end
    cull_mode = p.mode;
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the last handshake.
  task automatic accept(input pix_t p);
    int w;
    w = 0;
    out_ready = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_before_accept", in_ready, 1);
    drive(p);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_pixel(input pix_t p, input int pct, output logic [S-1:0] mask_got);
    logic [S-1:0] emask, ehit;
    logic [SW-1:0] ex, ey;
    logic [1:0] ei;
    int n, cyc;
    emask = '0;
    for (int s = 0; s < S; s++) begin
      ehit[s] = model_hit(p, s);
      emask[s] = ehit[s];
    end
    accept(p);
    n = 0; cyc = 0; mask_got = '0;
    while (n < S && cyc < 300) begin
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        ex = SW'(wrapn(sg(p.px) + sg(p.ox[n]), SW));
        ey = SW'(wrapn(sg(p.py) + sg(p.oy[n]), SW));
        ei = n[1:0];
        chk("beat_x", hit_out[0], ex);
        chk("beat_y", hit_out[1], ey);
        chk("beat_z", hit_out[2], p.z0[SW-1:0]);
        for (int c = 0; c < 3; c++) chk("beat_color", color_out[c], p.col[c]);
        chk("beat_hit", hit_valid_out, ehit[n]);
        chk("beat_idx", samp_idx_out, ei);
        chk("beat_last", last_out, n == S - 1);
        chk("beat_mask", covmask_out, (n == S - 1) ? emask : '0);
        chk("in_ready_busy", in_ready, n == S - 1);
        if (pct == 100) chk("beat_latency", cyc, n + 1);
        if (n == S - 1) mask_got = covmask_out;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    if (n < S) chk("beats_timeout", n, S);
    out_ready = 1'b1;
  endtask

  vec_t tbl [6];
  logic [S-1:0] mask;
  pix_t p;
  int w;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1;
    tri_in = '0; color_in = '0; pix_in = '0; offs_in = '0; cull_mode = '0;
    b_pix = '0; b_offs = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit_valid", hit_valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_covmask", covmask_out, 0);
    chk("rst_idx", samp_idx_out, 0);
    chk("rst_hit_out", hit_out[0] | hit_out[1] | hit_out[2], 0);
    chk("rst_color", color_out[0] | color_out[1] | color_out[2], 0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{swap: 1'b0, mode: 2'd0, mask: 4'b0011};
    tbl[1] = '{swap: 1'b1, mode: 2'd0, mask: 4'b0000};
    tbl[2] = '{swap: 1'b1, mode: 2'd1, mask: CULL_M};
    tbl[3] = '{swap: 1'b1, mode: 2'd2, mask: CULL_M};
    tbl[4] = '{swap: 1'b0, mode: 2'd3, mask: 4'b0011};
    tbl[5] = '{swap: 1'b0, mode: 2'd2, mask: 4'b0011};
    for (int i = 0; i < 6; i++) begin
      run_pixel(base_pix(tbl[i].swap, tbl[i].mode), 100, mask);
      chk("table_covmask", mask, tbl[i].mask);
    end

    // Single-sample ties: d0 = 0 hits, d1 = 0 does not.
    drive(base_pix(1'b0, 2'd0));
    b_offs = '0;
    for (int t = 0; t < 2; t++) begin
      b_pix[0] = (t == 0) ? SW'(0) : SW'(2048);
      b_pix[1] = (t == 0) ? SW'(1024) : SW'(2048);
      b_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("s1_valid", b_out_valid, 1);
      chk("s1_hit", b_hit_valid, t == 0);
      chk("s1_last", b_last, 1);
      chk("s1_mask", b_mask, t == 0);
      chk("s1_idx", b_idx, 0);
      chk("s1_x", b_hit_out[0], b_pix[0]);
      @(negedge clk);
      chk("s1_in_ready", b_in_ready, 1);
    end

    // Backpressure on beat 1 with a stray in_valid that must be ignored.
    p = base_pix(1'b0, 2'd0);
    accept(p);
    @(negedge clk);
    chk("bp_idx0", samp_idx_out, 0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(rand_pix());
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", samp_idx_out, 1);
      chk("bp_hit", hit_valid_out, 1);
      chk("bp_x", hit_out[0], SW'(1536));
      chk("bp_y", hit_out[1], SW'(1536));
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 1; n < S; n++) begin
      chk("bp_order", samp_idx_out, n);
      if (n == S - 1) chk("bp_covmask", covmask_out, 4'b0011);
      @(negedge clk);
    end
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_ready", in_ready, 1);

    // Reset mid-pixel.
    accept(base_pix(1'b0, 2'd0));
    w = 0;
    while (!(out_valid && samp_idx_out == 2) && w < 20) begin @(negedge clk); w++; end
    chk("mid_reached_idx2", samp_idx_out, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_mask", covmask_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pixel(base_pix(1'b0, 2'd0), 100, mask);
    chk("post_rst_covmask", mask, 4'b0011);

    for (int i = 0; i < 40; i++) run_pixel(rand_pix(), (i < 5) ? 100 : 60, mask);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
